// File: rtl/kbd_pkg.sv
// Shared constants and types for the keyboard translation stage:
// Set-2 scan codes, control ASCII codes and the prefix FSM state type.
package kbd_pkg;

    localparam logic [7:0] ScBreak  = 8'hF0;
    localparam logic [7:0] ScExt    = 8'hE0;
    localparam logic [7:0] ScLShift = 8'h12;
    localparam logic [7:0] ScRShift = 8'h59;
    localparam logic [7:0] ScCtrl   = 8'h14;
    localparam logic [7:0] ScCaps   = 8'h58;
    localparam logic [7:0] ScEnter  = 8'h5A;
    localparam logic [7:0] ScBksp   = 8'h66;
    localparam logic [7:0] ScEsc    = 8'h76;
    localparam logic [7:0] ScSpace  = 8'h29;
    localparam logic [7:0] ScTab    = 8'h0D;

    localparam logic [6:0] AsciiCr  = 7'h0D;
    localparam logic [6:0] AsciiBs  = 7'h08;
    localparam logic [6:0] AsciiEsc = 7'h1B;
    localparam logic [6:0] AsciiSp  = 7'h20;
    localparam logic [6:0] AsciiTab = 7'h09;

    typedef enum logic [1:0] {
        StIdle,
        StBrk,
        StExt,
        StExtBrk
    } prefix_state_e;

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous character FIFO; pointers carry one extra bit so full and empty
// are distinguishable. Depth must be a power of 2, at least 2.
module kbd_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 7
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW:0]     wptr_q, rptr_q;
    logic [Width-1:0]   mem_q [Depth];
    logic               do_push, do_pop;
    logic [AddrW:0]     ptr_one;

    assign ptr_one = {{AddrW{1'b0}}, 1'b1};
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                     (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    assign head_o  = mem_q[rptr_q[AddrW-1:0]];

    // A pop frees the slot this cycle, so a push while full still lands.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + ptr_one;
            if (do_pop)  rptr_q <= rptr_q + ptr_one;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/kbd_ascii.sv
// Set-2 scan code to ASCII translator with Apple-I style keyboard register.
// Define KBD_LOWERCASE_EN for lowercase letters with shift/caps selecting case.
module kbd_ascii #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLOCK_50,
    input  logic       res,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       kbd_clr,
    output logic [7:0] kbd_dbo,
    output logic       kbd_ovf,
    output logic       caps_led
);

    import kbd_pkg::*;

    prefix_state_e state_q, state_d;
    logic code_valid, code_brk, code_ext;
    logic lshift_q, lshift_d, rshift_q, rshift_d;
    logic lctrl_q, lctrl_d, rctrl_q, rctrl_d;
    logic caps_q, caps_d;
    logic shift, ctrl, letter_upper, hit;
    logic [15:0] entry;  // {hit, letter, base glyph, shifted glyph}
    logic [6:0] char_d, char_q;
    logic push_q, clr_q, pop, ovf_q;
    logic full, empty;
    logic [6:0] head;

    always_comb begin
        state_d    = state_q;
        code_valid = 1'b0;
        code_brk   = 1'b0;
        code_ext   = 1'b0;
        if (scan_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (scan_code == ScBreak)    state_d = StBrk;
                    else if (scan_code == ScExt) state_d = StExt;
                    else                         code_valid = 1'b1;
                end
                StBrk: begin
                    code_valid = 1'b1;
                    code_brk   = 1'b1;
                    state_d    = StIdle;
                end
                StExt: begin
                    if (scan_code == ScBreak) begin
                        state_d = StExtBrk;
                    end else begin
                        code_valid = 1'b1;
                        code_ext   = 1'b1;
                        state_d    = StIdle;
                    end
                end
                StExtBrk: begin
                    code_valid = 1'b1;
                    code_brk   = 1'b1;
                    code_ext   = 1'b1;
                    state_d    = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        lctrl_d  = lctrl_q;
        rctrl_d  = rctrl_q;
        caps_d   = caps_q;
        if (code_valid) begin
            if (!code_ext && scan_code == ScLShift) lshift_d = !code_brk;
            if (!code_ext && scan_code == ScRShift) rshift_d = !code_brk;
            if (scan_code == ScCtrl) begin
                if (code_ext) rctrl_d = !code_brk;
                else          lctrl_d = !code_brk;
            end
            if (!code_ext && !code_brk && scan_code == ScCaps) caps_d = !caps_q;
        end
    end

    always_comb begin
        entry = '0;
        case (scan_code)
            8'h1C: entry = {2'b11, 7'h41, 7'h41};  8'h32: entry = {2'b11, 7'h42, 7'h42};
            8'h21: entry = {2'b11, 7'h43, 7'h43};  8'h23: entry = {2'b11, 7'h44, 7'h44};
            8'h24: entry = {2'b11, 7'h45, 7'h45};  8'h2B: entry = {2'b11, 7'h46, 7'h46};
            8'h34: entry = {2'b11, 7'h47, 7'h47};  8'h33: entry = {2'b11, 7'h48, 7'h48};
            8'h43: entry = {2'b11, 7'h49, 7'h49};  8'h3B: entry = {2'b11, 7'h4A, 7'h4A};
            8'h42: entry = {2'b11, 7'h4B, 7'h4B};  8'h4B: entry = {2'b11, 7'h4C, 7'h4C};
            8'h3A: entry = {2'b11, 7'h4D, 7'h4D};  8'h31: entry = {2'b11, 7'h4E, 7'h4E};
            8'h44: entry = {2'b11, 7'h4F, 7'h4F};  8'h4D: entry = {2'b11, 7'h50, 7'h50};
            8'h15: entry = {2'b11, 7'h51, 7'h51};  8'h2D: entry = {2'b11, 7'h52, 7'h52};
            8'h1B: entry = {2'b11, 7'h53, 7'h53};  8'h2C: entry = {2'b11, 7'h54, 7'h54};
            8'h3C: entry = {2'b11, 7'h55, 7'h55};  8'h2A: entry = {2'b11, 7'h56, 7'h56};
            8'h1D: entry = {2'b11, 7'h57, 7'h57};  8'h22: entry = {2'b11, 7'h58, 7'h58};
            8'h35: entry = {2'b11, 7'h59, 7'h59};  8'h1A: entry = {2'b11, 7'h5A, 7'h5A};
            8'h45: entry = {2'b10, 7'h30, 7'h29};  8'h16: entry = {2'b10, 7'h31, 7'h21};
            8'h1E: entry = {2'b10, 7'h32, 7'h40};  8'h26: entry = {2'b10, 7'h33, 7'h23};
            8'h25: entry = {2'b10, 7'h34, 7'h24};  8'h2E: entry = {2'b10, 7'h35, 7'h25};
            8'h36: entry = {2'b10, 7'h36, 7'h5E};  8'h3D: entry = {2'b10, 7'h37, 7'h26};
            8'h3E: entry = {2'b10, 7'h38, 7'h2A};  8'h46: entry = {2'b10, 7'h39, 7'h28};
            8'h0E: entry = {2'b10, 7'h60, 7'h7E};  8'h4E: entry = {2'b10, 7'h2D, 7'h5F};
            8'h55: entry = {2'b10, 7'h3D, 7'h2B};  8'h54: entry = {2'b10, 7'h5B, 7'h7B};
            8'h5B: entry = {2'b10, 7'h5D, 7'h7D};  8'h5D: entry = {2'b10, 7'h5C, 7'h7C};
            8'h4C: entry = {2'b10, 7'h3B, 7'h3A};  8'h52: entry = {2'b10, 7'h27, 7'h22};
            8'h41: entry = {2'b10, 7'h2C, 7'h3C};  8'h49: entry = {2'b10, 7'h2E, 7'h3E};
            8'h4A: entry = {2'b10, 7'h2F, 7'h3F};
            ScEnter: entry = {2'b10, AsciiCr, AsciiCr};
            ScBksp:  entry = {2'b10, AsciiBs, AsciiBs};
            ScEsc:   entry = {2'b10, AsciiEsc, AsciiEsc};
            ScSpace: entry = {2'b10, AsciiSp, AsciiSp};
            ScTab:   entry = {2'b10, AsciiTab, AsciiTab};
            default: entry = '0;
        endcase
    end

    assign shift = lshift_q | rshift_q;
    assign ctrl  = lctrl_q | rctrl_q;
`ifdef KBD_LOWERCASE_EN
    assign letter_upper = shift ^ caps_q;
`else
    assign letter_upper = 1'b1;
`endif

    // Only Enter survives the extended prefix; every other extended make is dropped.
    assign hit = entry[15] && code_valid && !code_brk && (!code_ext || scan_code == ScEnter);

    always_comb begin
        char_d = entry[13:7];
        if (entry[14]) begin
            if (ctrl)               char_d = entry[13:7] & 7'h1F;
            else if (!letter_upper) char_d = entry[13:7] | 7'h20;
        end else if (shift) begin
            char_d = entry[6:0];
        end
    end

    assign pop = kbd_clr && !clr_q;

    always_ff @(posedge CLOCK_50) begin
        if (res) begin
            state_q  <= StIdle;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            lctrl_q  <= 1'b0;
            rctrl_q  <= 1'b0;
            caps_q   <= 1'b0;
            push_q   <= 1'b0;
            char_q   <= '0;
            clr_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            lctrl_q  <= lctrl_d;
            rctrl_q  <= rctrl_d;
            caps_q   <= caps_d;
            push_q   <= hit;
            char_q   <= char_d;
            clr_q    <= kbd_clr;
            // A simultaneous pop makes room, so only an unpaired push while full drops.
            ovf_q    <= ovf_q | (push_q && full && !pop);
        end
    end

    kbd_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (7)
    ) u_fifo (
        .clk_i   (CLOCK_50),
        .res_i   (res),
        .push_i  (push_q),
        .pop_i   (pop),
        .wdata_i (char_q),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign kbd_dbo  = empty ? 8'h00 : {1'b1, head};
    assign kbd_ovf  = ovf_q;
    assign caps_led = caps_q;

endmodule

// File: tb/tb_kbd_ascii.sv
// Scoreboard bench for kbd_ascii: expected characters are queued as scan codes
// are sent and checked against the keyboard register as the CPU pops them.
module tb_kbd_ascii;

    localparam int unsigned Depth = 4;
`ifdef KBD_LOWERCASE_EN
    localparam bit LowerEn = 1'b1;
`else
    localparam bit LowerEn = 1'b0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       res;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       kbd_clr;
    logic [7:0] kbd_dbo;
    logic       kbd_ovf;
    logic       caps_led;

    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] exp_q[$];

    kbd_ascii #(
        .FIFO_DEPTH (Depth)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .res        (res),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .kbd_clr    (kbd_clr),
        .kbd_dbo    (kbd_dbo),
        .kbd_ovf    (kbd_ovf),
        .caps_led   (caps_led)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        step();
        scan_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (2) step();
    endtask

    function automatic logic [6:0] letter(input logic [6:0] up, input logic sh, input logic cp);
        return (!LowerEn || (sh ^ cp)) ? up : (up | 7'h20);
    endfunction

    task automatic drain(input string name);
        logic [6:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (kbd_dbo !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL %s head: kbd_dbo=%h expected %h", name, kbd_dbo, {1'b1, e});
            end
            kbd_clr = 1'b1;
            repeat (10) step();
            kbd_clr = 1'b0;
            step();
        end
        n_checks++;
        if (kbd_dbo !== 8'h00) begin
            n_fail++;
            $display("FAIL %s empty: kbd_dbo=%h expected 00", name, kbd_dbo);
        end
    endtask

    task automatic test_reset();
        res = 1'b1; scan_valid = 1'b0; scan_code = 8'h00; kbd_clr = 1'b0;
        repeat (3) step();
        res = 1'b0;
        n_checks++;
        if (kbd_dbo !== 8'h00 || kbd_ovf !== 1'b0 || caps_led !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: dbo=%h ovf=%b caps=%b expected 00 0 0", kbd_dbo, kbd_ovf,
                     caps_led);
        end
    endtask

    task automatic test_first_char();
        logic [6:0] a;
        a = letter(7'h41, 1'b0, 1'b0);
        send(8'h1C);
        n_checks++;
        if (kbd_dbo !== 8'h00) begin
            n_fail++;
            $display("FAIL latency_n1: kbd_dbo=%h expected 00", kbd_dbo);
        end
        step();
        n_checks++;
        if (kbd_dbo !== {1'b1, a}) begin
            n_fail++;
            $display("FAIL latency_n2: kbd_dbo=%h expected %h", kbd_dbo, {1'b1, a});
        end
        exp_q.push_back(a);
        drain("first_char");
    endtask

    task automatic test_shift();
        send(8'h12); send(8'h16); send(8'hF0); send(8'h16); send(8'hF0); send(8'h12);
        send(8'h16);
        settle();
        exp_q.push_back(7'h21);
        exp_q.push_back(7'h31);
        drain("shift");
        // Pop edge while empty must be ignored.
        kbd_clr = 1'b1;
        repeat (3) step();
        kbd_clr = 1'b0;
        send(8'h1E);
        settle();
        exp_q.push_back(7'h32);
        drain("pop_empty");
    endtask

    task automatic test_ctrl_special();
        send(8'h14); send(8'h32); send(8'hF0); send(8'h32); send(8'hF0); send(8'h14);
        send(8'h14); send(8'h16); send(8'hF0); send(8'h14);
        send(8'hE0); send(8'h5A);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'h4A);
        settle();
        exp_q.push_back(7'h02);
        exp_q.push_back(7'h31);
        exp_q.push_back(7'h0D);
        drain("ctrl_ext");
        send(8'h5A); send(8'h66); send(8'h76); send(8'h29);
        settle();
        exp_q.push_back(7'h0D);
        exp_q.push_back(7'h08);
        exp_q.push_back(7'h1B);
        exp_q.push_back(7'h20);
        drain("specials");
        send(8'h0D);
        send(8'hE0); send(8'h14); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h14);
        send(8'h1C);
        settle();
        exp_q.push_back(7'h09);
        exp_q.push_back(7'h01);
        exp_q.push_back(letter(7'h41, 1'b0, 1'b0));
        drain("tab_rctrl");
    endtask

    task automatic test_overflow();
        n_checks++;
        if (kbd_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_initial: kbd_ovf=%b expected 0", kbd_ovf);
        end
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
        settle();
        exp_q.push_back(letter(7'h41, 1'b0, 1'b0));
        exp_q.push_back(letter(7'h42, 1'b0, 1'b0));
        exp_q.push_back(letter(7'h43, 1'b0, 1'b0));
        exp_q.push_back(letter(7'h44, 1'b0, 1'b0));
        n_checks++;
        if (kbd_ovf !== 1'b0 || kbd_dbo !== {1'b1, exp_q[0]}) begin
            n_fail++;
            $display("FAIL full_no_ovf: ovf=%b dbo=%h expected 0 %h", kbd_ovf, kbd_dbo,
                     {1'b1, exp_q[0]});
        end
        // Pop edge lands on the same edge as the push of F while full.
        send(8'h2B);
        kbd_clr = 1'b1;
        step();
        kbd_clr = 1'b0;
        step();
        void'(exp_q.pop_front());
        exp_q.push_back(letter(7'h46, 1'b0, 1'b0));
        n_checks++;
        if (kbd_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL push_pop_full: kbd_ovf=%b expected 0", kbd_ovf);
        end
        send(8'h34);
        n_checks++;
        if (kbd_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_early: kbd_ovf=%b expected 0", kbd_ovf);
        end
        step();
        n_checks++;
        if (kbd_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: kbd_ovf=%b expected 1", kbd_ovf);
        end
        drain("overflow");
        n_checks++;
        if (kbd_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: kbd_ovf=%b expected 1", kbd_ovf);
        end
    endtask

    task automatic test_caps();
        send(8'h58);
        n_checks++;
        if (caps_led !== 1'b1) begin
            n_fail++;
            $display("FAIL caps_on: caps_led=%b expected 1", caps_led);
        end
        send(8'hF0); send(8'h58);
        step();
        n_checks++;
        if (caps_led !== 1'b1) begin
            n_fail++;
            $display("FAIL caps_break: caps_led=%b expected 1", caps_led);
        end
        send(8'h1C);
        send(8'h12); send(8'h1C); send(8'h16); send(8'hF0); send(8'h12);
        settle();
        exp_q.push_back(letter(7'h41, 1'b0, 1'b1));
        exp_q.push_back(letter(7'h41, 1'b1, 1'b1));
        exp_q.push_back(7'h21);
        drain("caps");
    endtask

    task automatic test_back_to_back();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'h46);
        settle();
        exp_q.push_back(letter(7'h41, 1'b0, 1'b1));
        exp_q.push_back(letter(7'h41, 1'b0, 1'b1));
        exp_q.push_back(letter(7'h41, 1'b0, 1'b1));
        exp_q.push_back(7'h39);
        drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        send(8'h16);
        settle();
        send(8'hF0);
        res = 1'b1;
        step();
        res = 1'b0;
        n_checks++;
        if (kbd_dbo !== 8'h00 || kbd_ovf !== 1'b0 || caps_led !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: dbo=%h ovf=%b caps=%b expected 00 0 0", kbd_dbo, kbd_ovf,
                     caps_led);
        end
        send(8'h1C);
        settle();
        exp_q.push_back(letter(7'h41, 1'b0, 1'b0));
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_first_char();
        test_shift();
        test_ctrl_special();
        test_overflow();
        test_caps();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
